// File: rtl/term_write_sched.sv
// rtl/term_write_sched.sv - arbitrates CPU FIFO and aux characters into one-per-scanline terminal slots
// Optional TERM_UPCASE_EN folds a-z to A-Z on the issued character.
module term_write_sched #(
  parameter int FIFO_DEPTH = 4,
  parameter int CW         = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_we,
  input  logic [7:0]    cpu_data,
  output logic          cpu_busy,
  output logic          ovf,
  input  logic          aux_valid,
  input  logic [7:0]    aux_data,
  output logic          aux_ready,
  input  logic          tready,
  output logic          te,
  output logic [7:0]    ti,
  output logic [CW-1:0] count
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic RR_CPU = 1'b0;
  localparam logic RR_AUX = 1'b1;

  typedef enum logic [1:0] {IDLE, ISSUE, GUARD} state_t;

  state_t        state;
  logic          rr_last;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [7:0]    mem [FIFO_DEPTH];

  logic          cpu_pend;
  logic          full;
  logic          slot;
  logic          grant_cpu;
  logic          grant_aux;
  logic          push;
  logic          drop;
  logic [7:0]    sel_char;
  logic [CW-1:0] count_nxt;

  function automatic logic [7:0] fold(input logic [7:0] c);
`ifdef TERM_UPCASE_EN
    if (c >= 8'h61 && c <= 8'h7A)
      return c - 8'h20;
    else
      return c;
`else
    return c;
`endif
  endfunction

  always_comb begin
    cpu_pend  = (count != '0);
    full      = (count == CW'(FIFO_DEPTH));
    slot      = (state == IDLE) && tready;
    // On a tie, the requester that did not win the previous tie goes first.
    grant_cpu = slot && cpu_pend && (!aux_valid || rr_last == RR_AUX);
    grant_aux = slot && aux_valid && (!cpu_pend || rr_last == RR_CPU);
    aux_ready = grant_aux && !reset;
    // A pop on the same edge frees the slot, so a write into a full FIFO still lands.
    push      = cpu_we && (!full || grant_cpu);
    drop      = cpu_we && full && !grant_cpu;
    sel_char  = grant_cpu ? mem[rd_ptr] : (aux_data & 8'h7F);
    count_nxt = count + CW'(push) - CW'(grant_cpu);
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= cpu_data & 8'h7F;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rr_last  <= RR_AUX;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      cpu_busy <= 1'b0;
      ovf      <= 1'b0;
      te       <= 1'b0;
      ti       <= 8'h00;
    end else begin
      count    <= count_nxt;
      cpu_busy <= (count_nxt == CW'(FIFO_DEPTH));
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (grant_cpu)
        rd_ptr <= rd_ptr + PW'(1);
      if (drop)
        ovf <= 1'b1;

      case (state)
        IDLE: begin
          if (grant_cpu || grant_aux) begin
            ti    <= fold(sel_char);
            te    <= 1'b1;
            state <= ISSUE;
            if (cpu_pend && aux_valid)
              rr_last <= grant_cpu ? RR_CPU : RR_AUX;
          end
        end
        ISSUE: begin
          te    <= 1'b0;
          state <= GUARD;
        end
        GUARD: begin
          // Wait out the current slot so it cannot be used twice.
          if (!tready)
            state <= IDLE;
        end
        default: begin
          te    <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/term_write_sched.md
Name: term_write_sched

Overview:
- Schedules character writes into the Signetics-style terminal. The terminal accepts one character only on its one-cycle tready slot, which occurs once per scanline.
- Arbitrates between two requesters:
  - the CPU store path, decoded $D012 write, buffered in a small FIFO;
  - an auxiliary valid/ready source, e.g. a boot banner or serial echo.
- Drives the terminal's te/ti pair and returns the display-busy status bit for $D012 reads.

Parameters:
- FIFO_DEPTH, 4: CPU character FIFO entries; must be a power of 2, at least 2.
- CW, 3: width of the occupancy count; must equal log2(FIFO_DEPTH)+1.

Ports:
- clk  input  1  system clock
- reset  input  1  reset, asynchronous, active-high
- cpu_we  input  1  one-cycle CPU write strobe for $D012
- cpu_data  input  8  CPU write data
- cpu_busy  output  1  FIFO full; drives bit 7 of $D012 reads
- ovf  output  1  sticky flag: a CPU write was dropped while the FIFO was full
- aux_valid  input  1  auxiliary character pending
- aux_data  input  8  auxiliary character
- aux_ready  output  1  one-cycle accept pulse for aux
- tready  input  1  terminal ready slot, from the terminal
- te  output  1  terminal write enable, one-cycle pulse
- ti  output  8  terminal character; bit 7 is always 0
- count  output  CW  CPU FIFO occupancy

Behaviour:
- Reset (async) values:
  - te=0, ti=0, aux_ready=0, cpu_busy=0, ovf=0, count=0;
  - FIFO pointers=0, state=IDLE, rr_last=AUX, so the CPU wins the first tie.
- Reset mid-issue: te drops immediately and the in-flight character is lost.
- CPU enqueue:
  - cpu_we with count<FIFO_DEPTH writes cpu_data[6:0] (bit 7 cleared) at the write pointer.
  - cpu_we with count==FIFO_DEPTH drops the byte and sets ovf. ovf is cleared only by reset.
  - Enqueue and dequeue in the same cycle while full: the enqueue succeeds, count is unchanged, and ovf is not set.
  - Enqueue and dequeue in the same cycle while empty is impossible, because a dequeue requires a non-empty FIFO at the grant.
- cpu_busy = (count==FIFO_DEPTH), registered, updated the same edge as count.
- Pointers wrap modulo FIFO_DEPTH.
- State machine:
  - IDLE: on a cycle where tready=1 and (count>0 or aux_valid=1), grant one requester and go to ISSUE. Nothing happens while tready=0.
  - Grant rule: if only one requester is pending, grant it. If both are pending, grant the one that is not rr_last, then update rr_last.
  - CPU grant: ti <= FIFO head; pop at the same edge.
  - AUX grant: ti <= aux_data & 7F; aux_ready=1 for this single cycle (combinational from IDLE & tready & grant_aux).
  - ISSUE: te=1 for exactly one cycle with ti stable, then go to GUARD.
  - GUARD: te=0. Stay until tready is sampled 0, then go to IDLE. This prevents a double issue into one slot.
- Latency:
  - The tready slot at edge N produces te at cycle N+1.
  - Worst-case CPU character latency is (count+1) slots when aux is idle, or 2*(count+1) slots under full contention.
- ti holds its last value when te=0.
- aux_data is only sampled when aux_ready=1. aux_valid may drop at any time without a transfer.
- No character is issued when the FIFO is empty and aux_valid=0.

Optional Feature:
- Macro TERM_UPCASE_EN.
- Defined: the character selected for ti is folded to upper case when in 0x61..0x7A (subtract 0x20) before it is registered. This applies to both the CPU and AUX paths. FIFO contents stay unmodified.
- Undefined: the character passes through with bit 7 cleared only.

Test Plan:
- Reset then idle: tready pulses with no requests -> te never asserts; count=0, cpu_busy=0, ovf=0.
- Single CPU write 0xC1 with tready pulsed 5 cycles later -> te=1 exactly one cycle after the tready edge; ti=0x41; count goes 1->0.
- Fill: 5 writes 0x31..0x35 with no tready and FIFO_DEPTH=4 -> cpu_busy=1 after the 4th write; ovf=1 after the 5th. Four slots then yield 0x31..0x34 in order; cpu_busy=0 after the first pop.
- Contention: FIFO holds 0x41,0x42 and aux_valid=1 with aux_data=0x5A over 4 slots -> issue order 0x41, 0x5A, 0x42; aux_ready pulses once, in slot 2.
- Full plus slot edge: FIFO full, cpu_we and tready in the same cycle -> count stays at 4, ovf stays 0, and the new byte is issued 4 slots later.
- Assert reset during ISSUE -> te=0 immediately, count=0, state IDLE. With TERM_UPCASE_EN, writing 0x61 yields ti=0x41; without it, ti=0x61.
